// File: rtl/cellrv32_package.sv
// Shared types for the vector writeback block.
package cellrv32_package;

  // Writeback FSM: IDLE retires full/zero-mask heads directly, RD/WR perform
  // a read-modify-write merge for partially masked heads.
  typedef enum logic [1:0] {
    VWB_IDLE = 2'd0,
    VWB_RD   = 2'd1,
    VWB_WR   = 2'd2
  } vwb_state_t;

  localparam int VWB_STATE_W = 2;

endpackage

// File: rtl/vwb_fifo.sv
// Result buffer: fixed-depth FIFO with registered count, no pop-to-push bypass.
module vwb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, wrapping pointers and occupancy count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset flushes and zeroes storage so the head reads 0
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vwb.sv
// Vector writeback: buffers execution results, merges partial masks with the
// current register contents and tracks per-register pending status.
module vwb
  import cellrv32_package::*;
#(
  parameter int VREGS      = 32,
  parameter int ELEMENTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             reset,
  input  logic                             alloc_valid_i,
  input  logic [$clog2(VREGS)-1:0]         alloc_addr_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  input  logic [$clog2(VREGS)-1:0]         res_addr_i,
  input  logic [ELEMENTS-1:0]              res_mask_i,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]   res_data_i,
  output logic [$clog2(VREGS)-1:0]         rd_addr_o,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]   rd_data_i,
  output logic [ELEMENTS-1:0]              v_wr_en,
  output logic [$clog2(VREGS)-1:0]         v_wr_addr,
  output logic [ELEMENTS*DATA_WIDTH-1:0]   v_wr_data,
  output logic [VREGS-1:0]                 pending_o,
  output logic                             empty_o,
  output logic [VWB_STATE_W-1:0]           dbg_state_o
);

  localparam int AW = $clog2(VREGS);
  localparam int VW = ELEMENTS * DATA_WIDTH;
  localparam int FW = AW + ELEMENTS + VW;

  // Result handshake: a result transfers on a rising edge where res_valid_i
  // and res_ready_o are both high; ready only reflects FIFO space (a pop in
  // the same cycle does not free a slot early), and the producer must hold
  // addr/mask/data stable while valid is high and ready is low.

  logic [FW-1:0]       push_data, head;
  logic                fifo_empty, fifo_full, pop;
  logic [AW-1:0]       head_addr;
  logic [ELEMENTS-1:0] head_mask;
  logic [VW-1:0]       head_data;
  logic                mask_full, mask_zero;

  vwb_state_t          state_q, state_d;
  logic [VW-1:0]       merge_q, merge_d;
  logic [VREGS-1:0]    pending_q, pending_d;

  logic [ELEMENTS-1:0] wr_en;
  logic [AW-1:0]       wr_addr;
  logic [VW-1:0]       wr_data;

  assign push_data = {res_addr_i, res_mask_i, res_data_i};

  vwb_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .push_i  (res_valid_i && !fifo_full),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_addr = head[FW-1 -: AW];
  assign head_mask = head[VW +: ELEMENTS];
  assign head_data = head[VW-1:0];
  assign mask_full = &head_mask;
  assign mask_zero = ~|head_mask;

  // Writeback FSM: direct retire in IDLE, read-merge-write through RD/WR
  always_comb begin
    state_d = state_q;
    merge_d = merge_q;
    pop     = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      VWB_IDLE: begin
        if (!fifo_empty) begin
          if (mask_full) begin
            wr_en   = head_mask;
            wr_addr = head_addr;
            wr_data = head_data;
            pop     = 1'b1;
          end else if (mask_zero) begin
            // Nothing to write, but the register still leaves pending.
            pop = 1'b1;
          end else begin
            state_d = VWB_RD;
          end
        end
      end
      VWB_RD: begin
        merge_d = rd_data_i;
        state_d = VWB_WR;
      end
      VWB_WR: begin
        for (int i = 0; i < ELEMENTS; i++) begin
          wr_data[i*DATA_WIDTH +: DATA_WIDTH] = head_mask[i] ?
            head_data[i*DATA_WIDTH +: DATA_WIDTH] :
            merge_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        wr_en   = head_mask;
        wr_addr = head_addr;
        pop     = 1'b1;
        state_d = VWB_IDLE;
      end
      default: state_d = VWB_IDLE;
    endcase
  end

  // Pending scoreboard: retire clears, alloc sets, alloc wins on a tie
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_addr] = 1'b0;
    if (alloc_valid_i) pending_d[alloc_addr_i] = 1'b1;
  end

  // State, merge buffer and pending registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q   <= VWB_IDLE;
      merge_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      merge_q   <= merge_d;
      pending_q <= pending_d;
    end
  end

  // Reset forces the write port quiet so an in-flight merge is dropped.
  assign res_ready_o = reset || !fifo_full;
  assign v_wr_en     = reset ? '0 : wr_en;
  assign v_wr_addr   = reset ? '0 : wr_addr;
  assign v_wr_data   = reset ? '0 : wr_data;
  assign rd_addr_o   = reset ? '0 : head_addr;
  assign empty_o     = reset || (fifo_empty && (state_q == VWB_IDLE));
  assign pending_o   = pending_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vwb.sv
// Directed bench for vwb with a transaction-level model and literal checks.
module tb_vwb;

  localparam int VREGS    = 32;
  localparam int ELEMENTS = 4;
  localparam int DW       = 32;
  localparam int DEPTH    = 2;
  localparam int AW       = $clog2(VREGS);
  localparam int VW       = ELEMENTS * DW;
  localparam int EW       = AW + ELEMENTS + VW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                alloc_valid_i;
  logic [AW-1:0]       alloc_addr_i;
  logic                res_valid_i;
  logic                res_ready_o;
  logic [AW-1:0]       res_addr_i;
  logic [ELEMENTS-1:0] res_mask_i;
  logic [VW-1:0]       res_data_i;
  logic [AW-1:0]       rd_addr_o;
  logic [VW-1:0]       rd_data_i;
  logic [ELEMENTS-1:0] v_wr_en;
  logic [AW-1:0]       v_wr_addr;
  logic [VW-1:0]       v_wr_data;
  logic [VREGS-1:0]    pending_o;
  logic                empty_o;
  logic [1:0]          dbg_state_o;

  vwb #(
    .VREGS      (VREGS),
    .ELEMENTS   (ELEMENTS),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .reset         (reset),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_addr_i    (res_addr_i),
    .res_mask_i    (res_mask_i),
    .res_data_i    (res_data_i),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data_i),
    .v_wr_en       (v_wr_en),
    .v_wr_addr     (v_wr_addr),
    .v_wr_data     (v_wr_data),
    .pending_o     (pending_o),
    .empty_o       (empty_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- register file environment ----------------
  logic [VW-1:0] env_rf [VREGS];
  assign rd_data_i = env_rf[rd_addr_o];

  always @(posedge clk_i) begin
    for (int i = 0; i < ELEMENTS; i++)
      if (v_wr_en[i]) env_rf[v_wr_addr][i*DW +: DW] <= v_wr_data[i*DW +: DW];
  end

  function automatic logic [VW-1:0] init_val(input int r);
    logic [VW-1:0] v;
    if (r == 5) v = {32'hA, 32'hB, 32'hC, 32'hD};
    else for (int i = 0; i < ELEMENTS; i++) v[i*DW +: DW] = 32'(r * 16 + i) | 32'h100;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  // Entries wait in arrival order; a head becomes eligible the cycle after
  // it was accepted and after the previous entry retired. Full/zero masks
  // retire in that first cycle, partial masks two cycles later. Unmasked
  // elements of a write must carry the model's current register value.
  logic [EW-1:0]    exp_q [$];
  int               rdy_q [$];
  logic [VREGS-1:0] pend_m;
  logic [VW-1:0]    model_rf [VREGS];
  int               cyc;
  int               free_cyc;

  initial begin
    logic          exp_ready, retire;
    logic [AW-1:0] ha;
    logic [ELEMENTS-1:0] hm;
    logic [VW-1:0] hd, md;
    int            start, wc;
    cyc = 0;
    free_cyc = 0;
    pend_m = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      retire = 1'b0;
      if (reset) begin
        check("rst_ready", res_ready_o, 1);
        check("rst_wr_en", v_wr_en, 0);
        check("rst_empty", empty_o, 1);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_wr_addr", v_wr_addr, 0);
        check("rst_wr_data", v_wr_data, 0);
        exp_q.delete();
        rdy_q.delete();
        pend_m = '0;
        free_cyc = cyc + 1;
      end else begin
        exp_ready = (exp_q.size() < DEPTH);
        check("ready", res_ready_o, exp_ready);
        check("empty", empty_o, exp_q.size() == 0);
        check("pending", pending_o, pend_m);
        if (exp_q.size() > 0) begin
          {ha, hm, hd} = exp_q[0];
          check("rd_addr", rd_addr_o, ha);
          start = (rdy_q[0] > free_cyc) ? rdy_q[0] : free_cyc;
          wc = start + (((hm != '0) && (hm != '1)) ? 2 : 0);
          if (cyc == wc) begin
            retire = 1'b1;
            for (int i = 0; i < ELEMENTS; i++)
              md[i*DW +: DW] = hm[i] ? hd[i*DW +: DW] : model_rf[ha][i*DW +: DW];
            check("wr_en", v_wr_en, hm);
            if (hm != '0) begin
              check("wr_addr", v_wr_addr, ha);
              check("wr_data", v_wr_data, md);
            end
          end else begin
            check("wr_en_wait", v_wr_en, 0);
          end
        end else begin
          check("wr_en_empty", v_wr_en, 0);
        end
        if (retire) begin
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
          pend_m[ha] = 1'b0;
          if (hm != '0) model_rf[ha] = md;
          free_cyc = cyc + 1;
        end
        if (alloc_valid_i) pend_m[alloc_addr_i] = 1'b1;
        if (res_valid_i && exp_ready) begin
          exp_q.push_back({res_addr_i, res_mask_i, res_data_i});
          rdy_q.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offers a result until accepted; returns one step into the next cycle.
  task automatic push(input logic [AW-1:0] a, input logic [ELEMENTS-1:0] m,
                      input logic [VW-1:0] d);
    logic acc;
    int   n;
    res_valid_i = 1'b1;
    res_addr_i  = a;
    res_mask_i  = m;
    res_data_i  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk_i);
      acc = res_ready_o;
      tick();
      n++;
    end
    res_valid_i = 1'b0;
    check("push_accepted", acc, 1);
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  logic [AW-1:0]       t_addr [8];
  logic [ELEMENTS-1:0] t_mask [8];
  logic [VW-1:0]       t_data;

  initial begin
    alloc_valid_i = 1'b0;
    alloc_addr_i  = '0;
    res_valid_i   = 1'b0;
    res_addr_i    = '0;
    res_mask_i    = '0;
    res_data_i    = '0;
    for (int r = 0; r < VREGS; r++) begin
      env_rf[r]   = init_val(r);
      model_rf[r] = init_val(r);
    end

    repeat (2) tick();
    check("lit_rst_ready", res_ready_o, 1);
    check("lit_rst_empty", empty_o, 1);
    check("lit_rst_wr_en", v_wr_en, 0);
    check("lit_rst_pending", pending_o, 0);
    reset = 1'b0;

    // Full-mask write retires the cycle after acceptance.
    alloc(5'd3);
    check("s1_alloc_pending", pending_o[3], 1);
    push(5'd3, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1});
    check("s1_wr_en", v_wr_en, 4'b1111);
    check("s1_wr_data", v_wr_data, {32'd4, 32'd3, 32'd2, 32'd1});
    check("s1_pending_held", pending_o[3], 1);
    tick();
    check("s1_pending_clr", pending_o[3], 0);

    // Partial merge into v5 lands three cycles after acceptance.
    push(5'd5, 4'b0101, {4{32'd9}});
    check("s2_idle_no_wr", v_wr_en, 0);
    tick();
    check("s2_rd_addr", rd_addr_o, 5);
    check("s2_rd_no_wr", v_wr_en, 0);
    tick();
    check("s2_wr_en", v_wr_en, 4'b0101);
    check("s2_wr_data", v_wr_data, {32'hA, 32'd9, 32'hC, 32'd9});
    tick();
    check("s2_empty", empty_o, 1);

    // Back-to-back partial merges fill the buffer; order must hold on v10.
    push(5'd10, 4'b0011, {32'd5, 32'd6, 32'd7, 32'd8});
    push(5'd10, 4'b1100, {32'd1, 32'd2, 32'd3, 32'd4});
    res_valid_i = 1'b1;
    res_addr_i  = 5'd12;
    res_mask_i  = 4'b0110;
    res_data_i  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    #1;
    check("s3_ready_low_full", res_ready_o, 0);
    push(5'd12, 4'b0110, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    repeat (8) tick();
    check("s3_v10_order", env_rf[10], {32'd1, 32'd2, 32'd7, 32'd8});
    check("s3_v12_merge", env_rf[12], {32'h1C3, 32'hF2, 32'hF1, 32'h1C0});

    // Zero mask: pop without a write, pending cleared.
    alloc(5'd7);
    push(5'd7, 4'b0000, {4{32'hDEAD}});
    check("s4_no_wr", v_wr_en, 0);
    check("s4_not_empty", empty_o, 0);
    check("s4_pending_held", pending_o[7], 1);
    tick();
    check("s4_pending_clr", pending_o[7], 0);
    check("s4_empty", empty_o, 1);
    check("s4_v7_untouched", env_rf[7], init_val(7));

    // Reset during WR drops the merge.
    alloc(5'd20);
    push(5'd20, 4'b0110, {4{32'hEE}});
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("s5_wr_blocked", v_wr_en, 0);
    tick();
    reset = 1'b0;
    #1;
    check("s5_empty", empty_o, 1);
    check("s5_pending_zero", pending_o, 0);
    check("s5_v20_untouched", env_rf[20], init_val(20));

    // Alloc coincides with the retiring write to the same register.
    push(5'd2, 4'b1111, {32'h24, 32'h23, 32'h22, 32'h21});
    alloc_valid_i = 1'b1;
    alloc_addr_i  = 5'd2;
    check("s6_wr_en", v_wr_en, 4'b1111);
    check("s6_wr_addr", v_wr_addr, 2);
    tick();
    alloc_valid_i = 1'b0;
    check("s6_pending_set", pending_o[2], 1);

    // Mixed table streamed back-to-back with allocs; exercises pointer wrap.
    t_addr = '{5'd1, 5'd1, 5'd4, 5'd9, 5'd9, 5'd30, 5'd31, 5'd1};
    t_mask = '{4'b1111, 4'b1000, 4'b0001, 4'b0000, 4'b1010, 4'b0111, 4'b1111, 4'b0110};
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < ELEMENTS; i++) t_data[i*DW +: DW] = 32'(32'h1000 * k + i);
      alloc_valid_i = 1'b1;
      alloc_addr_i  = t_addr[k];
      push(t_addr[k], t_mask[k], t_data);
    end
    alloc_valid_i = 1'b0;
    repeat (20) tick();
    check("s7_v1_final", env_rf[1], {32'h1003, 32'h7002, 32'h7001, 32'h0000});
    check("s7_pending_final", pending_o, 32'h0000_0004);
    check("s7_empty", empty_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vwb.md
VWB -- requirements
Module: vwb

Interface
REQ-001 SHALL take parameter VREGS, default 32, number of vector registers.
REQ-002 SHALL take parameter ELEMENTS, default 4, elements per vector register.
REQ-003 SHALL take parameter DATA_WIDTH, default 32, bits per element.
REQ-004 SHALL take parameter FIFO_DEPTH, default 2, result-buffer entries (power of two, >=2).
REQ-005 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port alloc_valid_i  input  1  issue marks a destination register pending.
REQ-008 SHALL have port alloc_addr_i  input  $clog2(VREGS)  register being marked pending.
REQ-009 SHALL have port res_valid_i  input  1  execution result offered.
REQ-010 SHALL have port res_ready_o  output  1  result accepted when valid and ready are both high.
REQ-011 SHALL have port res_addr_i  input  $clog2(VREGS)  result destination register.
REQ-012 SHALL have port res_mask_i  input  ELEMENTS  element-write mask, bit i = element i.
REQ-013 SHALL have port res_data_i  input  ELEMENTS*DATA_WIDTH  result data, element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port rd_addr_o  output  $clog2(VREGS)  merge read address to the register file.
REQ-015 SHALL have port rd_data_i  input  ELEMENTS*DATA_WIDTH  combinational register-file read data for rd_addr_o.
REQ-016 SHALL have ports v_wr_en  output  ELEMENTS, v_wr_addr  output  $clog2(VREGS), and v_wr_data  output  ELEMENTS*DATA_WIDTH  forming the register-file write port.
REQ-017 SHALL have port pending_o  output  VREGS  bit r high means register r awaits writeback.
REQ-018 SHALL have port empty_o  output  1  FIFO empty and FSM in IDLE.

Function
REQ-019 SHALL buffer accepted results in a FIFO_DEPTH-entry FIFO of {addr, mask, data}.
REQ-020 SHALL drive res_ready_o = FIFO not full, with no same-cycle pop bypass; a result offered while full stays unaccepted.
REQ-021 SHALL run FSM states IDLE, RD, WR.
REQ-022 IDLE, FIFO empty: SHALL hold v_wr_en = 0 and stay in IDLE.
REQ-023 IDLE, head mask all ones: SHALL assert v_wr_en = mask, v_wr_addr = head addr, v_wr_data = head data in that cycle, pop, and stay in IDLE.
REQ-024 IDLE, head mask zero: SHALL pop without writing and clear the pending bit.
REQ-025 IDLE, head mask partial: SHALL go to RD.
REQ-026 RD: SHALL drive rd_addr_o = head addr, register rd_data_i into a merge buffer, and go to WR.
REQ-027 WR: SHALL write element i = mask[i] ? head data : merge buffer, set v_wr_en = head mask, pop, and return to IDLE.
REQ-028 Latency: a result accepted in cycle N SHALL be written no earlier than N+1 (full mask) or N+3 (partial mask), with one write per register-file cycle at most.
REQ-029 SHALL drive rd_addr_o = head addr in every state.
REQ-030 alloc_valid_i SHALL set pending_o[alloc_addr_i] on the next edge.
REQ-031 A write or zero-mask pop SHALL clear pending_o[head addr] on the next edge.
REQ-032 Alloc and clear of the same register in the same cycle SHALL leave the bit set.
REQ-033 Push and pop in the same cycle SHALL keep the count unchanged.
REQ-034 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 Writes SHALL retire in acceptance order, including consecutive writes to one register, with no reordering.

Reset
REQ-036 While reset is high at a clock edge: FIFO SHALL be flushed, FSM set to IDLE, pending_o = 0, merge buffer = 0.
REQ-037 Outputs during and after reset SHALL be: res_ready_o = 1, v_wr_en = 0, empty_o = 1, rd_addr_o = 0, v_wr_addr = 0, v_wr_data = 0.
REQ-038 Reset in RD or WR SHALL drop the in-flight merge with no register-file write.

Structure
REQ-039 The FSM state enum vwb_state_t SHALL live in cellrv32_package.
REQ-040 The FIFO SHALL be the single sub-module vwb_fifo, parameterised on width and depth; merge logic and FSM stay in vwb.

Verification
REQ-041 Scenario: alloc v3; push addr 3, mask 1111, data {4,3,2,1} -> v_wr_en = 1111 on the next cycle, pending_o[3] = 0 one cycle later.
REQ-042 Scenario: register v5 holds {A,B,C,D}; push addr 5, mask 0101, data {9,9,9,9} -> RD, then WR writes {A,9,C,9} with v_wr_en = 0101 three cycles after acceptance.
REQ-043 Scenario: hold the register file busy with partial merges and push 3 results back-to-back -> res_ready_o low at count 2, third accepted only after the first pop, writes in order.
REQ-044 Scenario: push mask 0000 to addr 7 -> no write, pending_o[7] cleared, FIFO pops.
REQ-045 Scenario: assert reset while in WR -> no write that cycle, empty_o = 1 and pending_o = 0 next cycle.
REQ-046 Scenario: alloc v2 in the same cycle a write to v2 retires -> pending_o[2] = 1 afterwards.
